// File: rtl/ysyx_23060201_ctrl_fsm_if.sv
// rtl/ysyx_23060201_ctrl_fsm_if.sv - fetch/decode/LSU/writeback control bundle for the NPC sequencer
interface ysyx_23060201_ctrl_fsm_if;
  logic       ifu_rvalid;
  logic       ifu_req;
  logic       inst_wen;
  logic [6:0] inst_op;
  logic [2:0] inst_func3;
  logic [4:0] inst_rd;
  logic       lsu_req;
  logic       lsu_we;
  logic       lsu_done;
  logic       gpr_wen;
  logic       pc_wen;

  modport master (
    output ifu_req, inst_wen, lsu_req, lsu_we, gpr_wen, pc_wen,
    input  ifu_rvalid, inst_op, inst_func3, inst_rd, lsu_done
  );

  modport slave (
    input  ifu_req, inst_wen, lsu_req, lsu_we, gpr_wen, pc_wen,
    output ifu_rvalid, inst_op, inst_func3, inst_rd, lsu_done
  );
endinterface

// File: rtl/ysyx_23060201_ctrl_fsm.sv
// rtl/ysyx_23060201_ctrl_fsm.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with halt detection
// Optional performance counters: define YSYX_23060201_PERF_CNT_EN.
module ysyx_23060201_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_23060201_ctrl_fsm_if.master  bus,
  output logic [2:0]                state_o,
  output logic                      halt,
  output logic [1:0]                halt_cause
`ifdef YSYX_23060201_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]          cycle_cnt,
  output logic [CNT_W-1:0]          instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    C_ALU   = 2'd0,
    C_BR    = 2'd1,
    C_LOAD  = 2'd2,
    C_STORE = 2'd3
  } cls_t;

  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state, next;
  cls_t        cls, dec_cls;
  logic        rd_nz;
  logic [1:0]  cause;
  logic [15:0] tcnt;
  logic        dec_bad;
  logic [1:0]  dec_cause;
  logic        halt_set;
  logic [1:0]  halt_code;
  logic        ifu_req_c, inst_wen_c, lsu_req_c, lsu_we_c, gpr_wen_c, pc_wen_c;

  always_comb begin
    dec_cls   = C_ALU;
    dec_bad   = 1'b0;
    dec_cause = 2'b00;
    case (bus.inst_op)
      7'b0110011, 7'b0010011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: dec_cls = C_ALU;
      7'b0000011:                         dec_cls = C_LOAD;
      7'b0100011:                         dec_cls = C_STORE;
      7'b1100011:                         dec_cls = C_BR;
      7'b1110011: begin
        // ebreak/ecall halt; other SYSTEM encodings stand in for CSR ops
        if (bus.inst_func3 == 3'b000) begin
          dec_bad   = 1'b1;
          dec_cause = 2'b01;
        end
      end
      default: begin
        dec_bad   = 1'b1;
        dec_cause = 2'b10;
      end
    endcase
  end

  always_comb begin
    next       = state;
    ifu_req_c  = 1'b0;
    inst_wen_c = 1'b0;
    lsu_req_c  = 1'b0;
    lsu_we_c   = 1'b0;
    gpr_wen_c  = 1'b0;
    pc_wen_c   = 1'b0;
    halt_set   = 1'b0;
    halt_code  = 2'b00;
    case (state)
      S_FETCH: begin
        ifu_req_c = 1'b1;
        if (bus.ifu_rvalid) begin
          inst_wen_c = 1'b1;
          next       = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_bad) begin
          next      = S_HALT;
          halt_set  = 1'b1;
          halt_code = dec_cause;
        end else begin
          next = S_EXEC;
        end
      end
      S_EXEC: next = (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
      S_MEM: begin
        lsu_req_c = 1'b1;
        lsu_we_c  = (cls == C_STORE);
        if (bus.lsu_done) begin
          next = S_WB;
        end else if (tcnt == TO_LAST) begin
          next      = S_HALT;
          halt_set  = 1'b1;
          halt_code = 2'b11;
        end
      end
      S_WB: begin
        pc_wen_c  = 1'b1;
        gpr_wen_c = (cls == C_ALU || cls == C_LOAD) && rd_nz;
        next      = S_FETCH;
      end
      S_HALT:  next = S_HALT;
      default: next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      cls   <= C_ALU;
      rd_nz <= 1'b0;
      cause <= 2'b00;
      tcnt  <= 16'd0;
    end else begin
      state <= next;
      if (state == S_DECODE) begin
        cls   <= dec_cls;
        rd_nz <= (bus.inst_rd != 5'd0);
      end
      if (halt_set) cause <= halt_code;
      tcnt <= (state == S_MEM && next == S_MEM) ? tcnt + 16'd1 : 16'd0;
    end
  end

  // Everything is forced low while reset is held, including the fetch request.
  assign bus.ifu_req  = ifu_req_c  & ~rst;
  assign bus.inst_wen = inst_wen_c & ~rst;
  assign bus.lsu_req  = lsu_req_c  & ~rst;
  assign bus.lsu_we   = lsu_we_c   & ~rst;
  assign bus.gpr_wen  = gpr_wen_c  & ~rst;
  assign bus.pc_wen   = pc_wen_c   & ~rst;
  assign state_o      = rst ? 3'd0 : state;
  assign halt         = ~rst & (state == S_HALT);
  assign halt_cause   = rst ? 2'b00 : cause;

`ifdef YSYX_23060201_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + 1'b1;
      if (state == S_WB) instret_cnt <= instret_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_cnt_w;
  assign unused_cnt_w = CNT_W;
`endif

endmodule
